// File: rtl/mem_stage_sram_ctrl_if.sv
// Bundles the MEM-stage request/response and the 16-bit asynchronous SRAM pins
// shared between the pipeline-side master and the SRAM controller.
interface mem_stage_sram_ctrl_if;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] alu_res;
  logic [31:0] val_Rm;
  logic        ready;
  logic [31:0] read_data;
  logic [17:0] sram_addr;
  logic [15:0] sram_wdata;
  logic [15:0] sram_rdata;
  logic        sram_we_n;

  modport master (
    output mem_read_en,
    output mem_write_en,
    output alu_res,
    output val_Rm,
    input  ready,
    input  read_data,
    input  sram_addr,
    input  sram_wdata,
    input  sram_we_n,
    output sram_rdata
  );

  modport slave (
    input  mem_read_en,
    input  mem_write_en,
    input  alu_res,
    input  val_Rm,
    output ready,
    output read_data,
    output sram_addr,
    output sram_wdata,
    output sram_we_n,
    input  sram_rdata
  );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// Splits each 32-bit MEM-stage load/store into two 16-bit SRAM phases of
// WAIT_CYCLES clocks each, freezing the pipeline until the access completes.
module mem_stage_sram_ctrl #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_stage_sram_ctrl_if.slave  bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD_LO = 3'd1;
  localparam logic [2:0] RD_HI = 3'd2;
  localparam logic [2:0] WR_LO = 3'd3;
  localparam logic [2:0] WR_HI = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]  r_state;
  logic [3:0]  r_cnt;
  logic [16:0] r_word;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  logic        w_req;
  logic        w_last;
  logic [31:0] w_diff;
  logic [16:0] w_word;
  logic        w_unused;
  logic [2:0]  w_next_phase;
  logic        w_ready;
  logic        w_we_n;
  logic [17:0] w_addr;
  logic [15:0] w_wdata;

  assign w_req    = bus.mem_read_en | bus.mem_write_en;
  assign w_last   = (r_cnt == 4'(WAIT_CYCLES - 1));
  // Byte offset from the data-memory base, reduced to a 17-bit word index.
  assign w_diff   = bus.alu_res - 32'(BASE_ADDR);
  assign w_word   = w_diff[18:2];
  assign w_unused = &{1'b0, w_diff[31:19], w_diff[1:0]};

  always_comb begin
    w_next_phase = IDLE;
    w_ready      = 1'b0;
    w_we_n       = 1'b1;
    w_addr       = 18'd0;
    w_wdata      = 16'd0;
    case (r_state)
      IDLE: begin
        w_ready = ~w_req;
      end
      RD_LO: begin
        w_next_phase = RD_HI;
        w_addr       = {r_word, 1'b0};
      end
      RD_HI: begin
        w_next_phase = DONE;
        w_addr       = {r_word, 1'b1};
      end
      WR_LO: begin
        w_next_phase = WR_HI;
        w_we_n       = 1'b0;
        w_addr       = {r_word, 1'b0};
        w_wdata      = r_wdata[15:0];
      end
      WR_HI: begin
        w_next_phase = DONE;
        w_we_n       = 1'b0;
        w_addr       = {r_word, 1'b1};
        w_wdata      = r_wdata[31:16];
      end
      DONE: begin
        w_ready = 1'b1;
      end
      default: begin
        w_ready = 1'b0;
      end
    endcase
  end

  // Enables are only sampled in IDLE; the completing instruction's still-high
  // enables during DONE must not start a second access.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_word  <= 17'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_word  <= w_word;
            r_wdata <= bus.val_Rm;
            r_cnt   <= 4'd0;
            r_state <= bus.mem_write_en ? WR_LO : RD_LO;
          end
        end
        RD_LO, RD_HI, WR_LO, WR_HI: begin
          if (w_last) begin
            r_cnt   <= 4'd0;
            r_state <= w_next_phase;
            if (r_state == RD_LO) r_rdata[15:0]  <= bus.sram_rdata;
            if (r_state == RD_HI) r_rdata[31:16] <= bus.sram_rdata;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        DONE: begin
          r_cnt   <= 4'd0;
          r_state <= IDLE;
        end
        default: begin
          r_cnt   <= 4'd0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready      = w_ready;
  assign bus.sram_we_n  = w_we_n;
  assign bus.sram_addr  = w_addr;
  assign bus.sram_wdata = w_wdata;
  assign bus.read_data  = r_rdata;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Self-checking bench: per-cycle expected bus snapshots are queued as each
// access is issued and compared one per clock against the controller.
module tb_mem_stage_sram_ctrl;

  localparam int BASE = 1024;
  localparam int WAIT = 2;

  typedef struct packed {
    logic        ready;
    logic        we_n;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_stage_sram_ctrl_if bus_if();

  mem_stage_sram_ctrl #(
    .BASE_ADDR   (BASE),
    .WAIT_CYCLES (WAIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  exp_t        exp_q[$];
  exp_t        e;
  exp_t        o;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_rdata = 32'd0;
  logic [15:0] ref_mem [0:255];
  logic [15:0] sram_mem [0:255];
  logic        sram_written [0:255];

  function automatic logic [15:0] pat(input int a);
    return 16'(a * 16'h0101) ^ 16'h5A5A;
  endfunction

  // Asynchronous SRAM model: combinational read, write captured while we_n is low.
  assign bus_if.sram_rdata = sram_written[bus_if.sram_addr[7:0]] ?
                             sram_mem[bus_if.sram_addr[7:0]] : pat(int'(bus_if.sram_addr[7:0]));

  always @(posedge clk) begin
    if (bus_if.sram_we_n === 1'b0) begin
      sram_mem[bus_if.sram_addr[7:0]]     <= bus_if.sram_wdata;
      sram_written[bus_if.sram_addr[7:0]] <= 1'b1;
    end
  end

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{1'b1, 1'b1, 18'd0, 16'd0, exp_rdata});
  endtask

  task automatic push_access(input bit wr, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] off;
    logic [17:0] lo, hi;
    off = addr - 32'(BASE);
    lo  = {off[18:2], 1'b0};
    hi  = {off[18:2], 1'b1};
    exp_q.push_back('{1'b0, 1'b1, 18'd0, 16'd0, exp_rdata});
    if (wr) begin
      for (int i = 0; i < WAIT; i++) exp_q.push_back('{1'b0, 1'b0, lo, data[15:0], exp_rdata});
      for (int i = 0; i < WAIT; i++) exp_q.push_back('{1'b0, 1'b0, hi, data[31:16], exp_rdata});
      ref_mem[lo[7:0]] = data[15:0];
      ref_mem[hi[7:0]] = data[31:16];
    end else begin
      for (int i = 0; i < WAIT; i++) exp_q.push_back('{1'b0, 1'b1, lo, 16'd0, exp_rdata});
      exp_rdata[15:0] = ref_mem[lo[7:0]];
      for (int i = 0; i < WAIT; i++) exp_q.push_back('{1'b0, 1'b1, hi, 16'd0, exp_rdata});
      exp_rdata[31:16] = ref_mem[hi[7:0]];
    end
    exp_q.push_back('{1'b1, 1'b1, 18'd0, 16'd0, exp_rdata});
  endtask

  task automatic drive(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] data);
    bus_if.mem_read_en  = rd;
    bus_if.mem_write_en = wr;
    bus_if.alu_res      = addr;
    bus_if.val_Rm       = data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_rdata = 32'd0;
    push_idle(5);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = '{bus_if.ready, bus_if.sram_we_n, bus_if.sram_addr, bus_if.sram_wdata, bus_if.read_data};
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL reset_idle cycle %0d: got %h required %h", c, o, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store();
    drive(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
    push_access(1'b1, 32'd1028, 32'hDEADBEEF);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = '{bus_if.ready, bus_if.sram_we_n, bus_if.sram_addr, bus_if.sram_wdata, bus_if.read_data};
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL store cycle %0d: got %h required %h", c, o, e);
      end
      @(posedge clk); #1;
      if (c == 0) drive(1'b0, 1'b1, 32'h0000_0F00, 32'h1111_2222);
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic test_load();
    drive(1'b1, 1'b0, 32'd1028, 32'd0);
    push_access(1'b0, 32'd1028, 32'd0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = '{bus_if.ready, bus_if.sram_we_n, bus_if.sram_addr, bus_if.sram_wdata, bus_if.read_data};
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL load cycle %0d: got %h required %h", c, o, e);
      end
      @(posedge clk); #1;
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic test_both_enables();
    drive(1'b1, 1'b1, 32'd1024, 32'h12345678);
    push_access(1'b1, 32'd1024, 32'h12345678);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = '{bus_if.ready, bus_if.sram_we_n, bus_if.sram_addr, bus_if.sram_wdata, bus_if.read_data};
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL both_en cycle %0d: got %h required %h", c, o, e);
      end
      @(posedge clk); #1;
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b0, 32'd1032, 32'd0);
    push_access(1'b0, 32'd1032, 32'd0);
    push_access(1'b1, 32'd1036, 32'hCAFEF00D);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = '{bus_if.ready, bus_if.sram_we_n, bus_if.sram_addr, bus_if.sram_wdata, bus_if.read_data};
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL back_to_back cycle %0d: got %h required %h", c, o, e);
      end
      @(posedge clk); #1;
      if (c == 5) drive(1'b0, 1'b1, 32'd1036, 32'hCAFEF00D);
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic test_reset_mid_write();
    drive(1'b0, 1'b1, 32'd1040, 32'h0BADCAFE);
    push_access(1'b1, 32'd1040, 32'h0BADCAFE);
    exp_q = exp_q[0:3];
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = '{bus_if.ready, bus_if.sram_we_n, bus_if.sram_addr, bus_if.sram_wdata, bus_if.read_data};
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL reset_mid_write cycle %0d: got %h required %h", c, o, e);
      end
      @(posedge clk); #1;
      if (c == 2) rst = 1'b1;
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    exp_rdata = 32'd0;
    push_idle(3);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = '{bus_if.ready, bus_if.sram_we_n, bus_if.sram_addr, bus_if.sram_wdata, bus_if.read_data};
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL after_reset_idle cycle %0d: got %h required %h", c, o, e);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i]      = pat(i);
      sram_mem[i]     = 16'd0;
      sram_written[i] = 1'b0;
    end
    test_reset();
    test_store();
    test_load();
    test_both_enables();
    test_back_to_back();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_sram_ctrl.md
Name: mem_stage_sram_ctrl

Overview:
- Sequences data-memory accesses of the MEM stage onto an off-chip 16-bit asynchronous SRAM.
- Takes the registered EXE-stage outputs (mem read/write enables, ALU result as byte address, Rm value as store data) and splits each 32-bit access into two 16-bit SRAM phases.
- Drives `ready` low to freeze the pipeline for the whole access, and returns the assembled 32-bit load word.

Parameters:
- `BASE_ADDR`, 1024: byte address of data-memory word 0; subtracted from the ALU result.
- `WAIT_CYCLES`, 2: clock cycles each 16-bit SRAM phase is held; legal range 1..15.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `mem_read_en`  in  1  load request from the EXE stage register.
- `mem_write_en`  in  1  store request from the EXE stage register.
- `alu_res`  in  32  byte address of the access.
- `val_Rm`  in  32  store data.
- `ready`  out  1  1 = no access pending or access completing this cycle; 0 = freeze pipeline.
- `read_data`  out  32  last completed load word.
- `sram_addr`  out  18  SRAM half-word address.
- `sram_wdata`  out  16  SRAM write data.
- `sram_rdata`  in  16  SRAM read data, valid combinationally while the address is held.
- `sram_we_n`  out  1  SRAM write enable, active low.

Behaviour:
- Reset:
  - Any rising edge with rst=1 forces state IDLE and clears the phase counter.
  - It also clears the latched address, latched write data and `read_data` to 0.
  - Reset mid-access aborts that access; no further SRAM write cycle follows.
- Address mapping:
  - word = (alu_res - BASE_ADDR) >> 2, computed mod 2^32, truncated to 17 bits.
  - Low half-word address = {word, 1'b0}; high half-word address = {word, 1'b1}.
  - alu_res[1:0] is ignored.
- States: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
- IDLE:
  - No request: ready=1, sram_we_n=1, sram_addr=0, sram_wdata=0.
  - Any request: ready=0 in the same cycle. On the edge, latch the mapped word address and val_Rm, and clear the counter.
  - Next state is WR_LO if mem_write_en=1 (write has priority when both enables are set), else RD_LO.
- Access phases:
  - Each of RD_LO, RD_HI, WR_LO, WR_HI lasts exactly WAIT_CYCLES cycles.
  - The counter increments each cycle and resets to 0 on a phase change; ready=0 throughout.
- RD_LO / RD_HI:
  - sram_addr = low / high half-word address; sram_we_n=1.
  - On the last cycle of RD_LO, capture sram_rdata into read_data[15:0].
  - On the last cycle of RD_HI, capture sram_rdata into read_data[31:16].
  - RD_LO goes to RD_HI; RD_HI goes to DONE.
- WR_LO / WR_HI:
  - sram_addr = low / high half-word address; sram_we_n=0 for every cycle of the phase.
  - sram_wdata = latched data[15:0] / [31:16].
  - read_data is unchanged.
  - WR_LO goes to WR_HI; WR_HI goes to DONE.
- DONE:
  - ready=1 for exactly one cycle; sram_we_n=1; read_data holds the final word.
  - Next state is IDLE unconditionally; the still-asserted enables of the completing instruction are ignored.
  - A new request is only evaluated in IDLE, i.e. on the following cycle.
- Latency:
  - ready is low for 1 + 2*WAIT_CYCLES consecutive cycles per access and high in the DONE cycle.
  - With WAIT_CYCLES=2 that is 5 low cycles, then 1 high cycle.
- Requests changing during an access are ignored; the latched address and data are used.
- read_data changes only on completed read phases or reset.
- sram_we_n is never 0 outside WR_LO/WR_HI.

Test Plan:
- Reset, then idle:
  - Stimulus: rst=1 for 2 cycles, then no enables for 5 cycles.
  - Required: ready=1 every idle cycle, sram_we_n=1, read_data=0, sram_addr=0.
- Store:
  - Stimulus: mem_write_en=1, alu_res=1028, val_Rm=0xDEADBEEF, WAIT_CYCLES=2.
  - Required: ready=0 for 5 cycles.
  - Required: sram_addr=2 with sram_wdata=0xBEEF and we_n=0 for 2 cycles, then sram_addr=3 with wdata=0xDEAD and we_n=0 for 2 cycles.
  - Required: DONE cycle ready=1, we_n=1.
- Load back:
  - Stimulus: mem_read_en=1, alu_res=1028, SRAM model returns 0xBEEF at address 2 and 0xDEAD at address 3.
  - Required: we_n stays 1, ready low 5 cycles, read_data=0xDEADBEEF in the DONE cycle.
- Both enables set:
  - Stimulus: read and write enables both 1, alu_res=1024, val_Rm=0x12345678.
  - Required: write sequence to addresses 0 and 1; read_data unchanged.
- Back-to-back:
  - Stimulus: load at alu_res=1032, then a store issued on the cycle after DONE.
  - Required: no merged or skipped phases; exactly one IDLE cycle with ready=0 before the store's WR_LO.
- Reset mid-write:
  - Stimulus: rst=1 during the first WR_HI cycle.
  - Required: next cycle is IDLE, we_n=1, ready=1 (no request), read_data=0.
